uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, idle-cycle limit while a packet is locked (used only under UART_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  NUM_REQ x 8  per-requester byte.
REQ-007 SHALL have port req_last  input  NUM_REQ  marks the final byte of a packet.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester byte accepted.
REQ-009 SHALL have port tx_data_valid  output  1  byte valid to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-011 SHALL have port tx_data_ready  input  1  UART transmitter accepts a byte.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_REQ)  index of the current owner.
REQ-013 SHALL have port busy  output  1  high while in LOCKED.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse when a lock is forcibly released.

Function
REQ-015 SHALL implement the states IDLE and LOCKED.
REQ-016 In IDLE, with any req_valid high, SHALL register the winner into grant_id and move to LOCKED on the next edge. This is one cycle of arbitration latency. No byte transfers in IDLE.
REQ-017 SHALL pick the winner round-robin: the first valid index strictly after last_owner, wrapping modulo NUM_REQ.
REQ-018 In LOCKED, tx_data_valid SHALL equal req_valid[grant_id] and tx_data SHALL equal req_data[grant_id], both combinationally.
REQ-019 In LOCKED, req_ready[grant_id] SHALL equal tx_data_ready. Every other req_ready bit SHALL be 0. In IDLE, all req_ready bits SHALL be 0.
REQ-020 A beat completes when tx_data_valid and tx_data_ready are both high.
REQ-021 A completed beat with req_last[grant_id] high SHALL update last_owner to grant_id and return the block to IDLE on the next edge.
REQ-022 The grant SHALL NOT change mid-packet, whatever other requesters assert.
REQ-023 A requester that deasserts req_valid mid-packet SHALL keep the grant, except as allowed by REQ-031.
REQ-024 After a last beat, the block SHALL spend one IDLE cycle before the next grant, including back-to-back packets from the same requester. That requester is eligible again only if no other requester is valid.
REQ-025 Only one requester valid SHALL always win, regardless of last_owner.
REQ-026 Outputs SHALL not depend on req_* of non-granted indices.

Reset
REQ-027 Asserting rst_n low SHALL immediately force IDLE, set last_owner to NUM_REQ-1 (so index 0 wins first), and drive grant_id=0, busy=0, timeout=0, tx_data_valid=0 and all req_ready bits to 0. tx_data is don't-care.
REQ-028 Reset asserted mid-packet SHALL abandon the packet without any further beat.
REQ-029 Deassertion of rst_n SHALL be synchronised externally. The block SHALL need no internal reset synchroniser.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN SHALL compile the lock-timeout feature in or out.
REQ-031 With UART_ARB_TIMEOUT_EN defined:
- a counter SHALL count LOCKED cycles with req_valid[grant_id] low, and SHALL clear on any cycle where req_valid[grant_id] is high;
- on reaching TIMEOUT_CYC, the block SHALL pulse timeout for one cycle, set last_owner to grant_id and return to IDLE.
REQ-032 Without UART_ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied to 0, and locks SHALL be held indefinitely.

Structure
REQ-033 Package uart_pkg SHALL hold the arb_state_t enum (IDLE, LOCKED) and the constant UART_BYTE_W=8.
REQ-034 Sub-module rr_pick SHALL be purely combinational: given a valid vector and last_owner, it returns the winner index and an any-valid flag.

Verification
REQ-035 Single requester: req_valid[2]=1 with 3 bytes (last on the 3rd) and tx_data_ready=1 -> grant_id=2 one cycle later, 3 beats delivered in order, then IDLE.
REQ-036 Fairness: all 4 requesters continuously sending 1-byte packets, starting after reset -> grant order 0,1,2,3,0, with an IDLE cycle between each.
REQ-037 Lock hold: requester 1 owns the lock and idles 5 cycles mid-packet while requester 0 is valid -> grant stays 1 and req_ready[0]=0 throughout.
REQ-038 Backpressure: tx_data_ready=0 for 10 cycles during the lock -> tx_data stable, req_ready[grant_id]=0, no beat lost or duplicated.
REQ-039 Reset mid-packet: rst_n pulsed low after byte 2 of 4 -> outputs reset immediately, no further beats, next grant goes to index 0.
REQ-040 With UART_ARB_TIMEOUT_EN defined and TIMEOUT_CYC=8: the owner idles 8 cycles -> timeout pulses once, the block returns to IDLE, and the next valid requester after the owner wins.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;
  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after last_owner, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Offsets 1..NUM_REQ, so last_owner itself is visited last.
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    idx       = '0;
    any_valid = |valid;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locking round-robin arbiter feeding one UART transmitter.
// Optional lock timeout compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 1023,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][UART_BYTE_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                    req_last,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  tx_data_valid,
  output logic [UART_BYTE_W-1:0]                tx_data,
  input  logic                                  tx_data_ready,
  output logic [IDX_W-1:0]                      grant_id,
  output logic                                  busy,
  output logic                                  timeout
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] last_owner, owner_nxt, grant_nxt;
  logic [IDX_W-1:0] pick_winner;
  logic             pick_any;
  logic             locked, own_valid, own_last, beat, to_hit;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid      (req_valid),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .any_valid  (pick_any)
  );

  assign locked    = (state == LOCKED);
  assign own_valid = req_valid[grant_id];
  assign own_last  = req_last[grant_id];
  assign beat      = locked && own_valid && tx_data_ready;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle of the owner.
  assign to_hit = locked && !own_valid && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          idle_cnt <= '0;
    else if (!locked || own_valid || to_hit) idle_cnt <= '0;
    else                                 idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign to_hit             = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = LOCKED;
          grant_nxt = pick_winner;
        end
      end
      LOCKED: begin
        if ((beat && own_last) || to_hit) begin
          state_nxt = IDLE;
          owner_nxt = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (locked) req_ready[grant_id] = tx_data_ready;
  end

  assign tx_data_valid = locked && own_valid;
  assign tx_data       = req_data[grant_id];
  assign busy          = locked;
  assign timeout       = to_hit;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (NUM_REQ=4, TIMEOUT_CYC=8).
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int N = 4;
  localparam int TO = 8;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic [N-1:0]                      req_valid = '0;
  logic [N-1:0][UART_BYTE_W-1:0]     req_data = '0;
  logic [N-1:0]                      req_last = '0;
  logic [N-1:0]                      req_ready;
  logic                              tx_data_valid;
  logic [UART_BYTE_W-1:0]            tx_data;
  logic                              tx_data_ready = 1'b1;
  logic [1:0]                        grant_id;
  logic                              busy;
  logic                              timeout;

  int checks = 0;
  int failures = 0;
  logic [7:0] beat_data[$];
  logic [1:0] beat_owner[$];

  uart_tx_arb #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data_valid(tx_data_valid),
    .tx_data(tx_data), .tx_data_ready(tx_data_ready), .grant_id(grant_id),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so the negedge view is what the next edge commits.
  always @(negedge clk)
    if (rst_n && tx_data_valid && tx_data_ready) begin
      beat_data.push_back(tx_data);
      beat_owner.push_back(grant_id);
    end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_data_ready = 1'b1;
    repeat (2) step;
    rst_n = 1'b1;
    beat_data.delete(); beat_owner.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '1; tx_data_ready = 1'b1;
    step;
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if (tx_data_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_data_valid); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
  endtask

  task automatic test_single;
    logic [7:0] exp_d[3] = '{8'hA1, 8'hA2, 8'hA3};
    do_reset;
    req_valid = 4'b0100; req_data[2] = 8'hA1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_idle_ready got=%b exp=0000", req_ready); end
    step;
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_grant got=%0d exp=2", grant_id); end
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    checks++; if (tx_data !== 8'hA1) begin failures++; $display("FAIL single_data0 got=%h exp=a1", tx_data); end
    step; req_data[2] = 8'hA2;
    step; req_data[2] = 8'hA3; req_last[2] = 1'b1;
    step; req_valid = '0; req_last = '0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_back_idle got=%b exp=0", busy); end
    checks++; if (beat_data.size() !== 3) begin failures++; $display("FAIL single_beats got=%0d exp=3", beat_data.size()); end
    for (int i = 0; i < 3 && i < beat_data.size(); i++) begin
      checks++; if (beat_data[i] !== exp_d[i]) begin failures++; $display("FAIL single_order[%0d] got=%h exp=%h", i, beat_data[i], exp_d[i]); end
    end
  endtask

  task automatic test_fairness;
    logic [1:0] exp_o[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset;
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i] = 8'(8'h10 + i);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'((i % 2) != 0)) begin failures++; $display("FAIL fair_busy[%0d] got=%b exp=%b", i, busy, (i % 2) != 0); end
    end
    #1;
    checks++; if (beat_owner.size() !== 5) begin failures++; $display("FAIL fair_beats got=%0d exp=5", beat_owner.size()); end
    for (int i = 0; i < 5 && i < beat_owner.size(); i++) begin
      checks++; if (beat_owner[i] !== exp_o[i]) begin failures++; $display("FAIL fair_order[%0d] got=%0d exp=%0d", i, beat_owner[i], exp_o[i]); end
    end
  endtask

  task automatic test_lock_hold;
    do_reset;
    req_valid = 4'b0010; req_data[1] = 8'h51;
    step;
    step; req_valid = 4'b0001; req_data[0] = 8'hEE; req_last[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL hold_grant[%0d] got=%0d/%b exp=1/1", i, grant_id, busy); end
      checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL hold_ready0[%0d] got=%b exp=0", i, req_ready[0]); end
      step;
    end
    req_valid = 4'b0011; req_data[1] = 8'h52; req_last[1] = 1'b1;
    #1;
    checks++; if (tx_data !== 8'h52) begin failures++; $display("FAIL hold_resume got=%h exp=52", tx_data); end
    step; req_valid = 4'b0001; req_last[1] = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", busy); end
    step; req_valid = '0;
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL hold_next got=%0d exp=0", grant_id); end
    checks++; if (beat_data.size() !== 2 || beat_data[0] !== 8'h51 || beat_data[1] !== 8'h52)
      begin failures++; $display("FAIL hold_beats got=%0d beats exp=2 (51,52)", beat_data.size()); end
  endtask

  task automatic test_backpressure;
    do_reset;
    req_valid = 4'b1000; req_data[3] = 8'h31;
    step;
    step; req_data[3] = 8'h32; tx_data_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (tx_data !== 8'h32 || tx_data_valid !== 1'b1) begin failures++; $display("FAIL bp_data[%0d] got=%h/%b exp=32/1", i, tx_data, tx_data_valid); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, req_ready); end
      step;
    end
    tx_data_ready = 1'b1;
    step; req_data[3] = 8'h33; req_last[3] = 1'b1;
    step; req_valid = '0; req_last = '0;
    #1;
    checks++; if (beat_data.size() !== 3) begin failures++; $display("FAIL bp_beats got=%0d exp=3", beat_data.size()); end
    for (int i = 0; i < 3 && i < beat_data.size(); i++) begin
      checks++; if (beat_data[i] !== 8'(8'h31 + i)) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, beat_data[i], 8'(8'h31 + i)); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req_valid = 4'b0100; req_data[2] = 8'h41;
    step;
    step; req_data[2] = 8'h42;
    step; req_data[2] = 8'h43;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin failures++; $display("FAIL rmid_state got=%b/%0d exp=0/0", busy, grant_id); end
    checks++; if (tx_data_valid !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL rmid_outs got=%b/%b exp=0/0000", tx_data_valid, req_ready); end
    step;
    rst_n = 1'b1; req_valid = 4'b0101; req_data[0] = 8'h70; req_last[0] = 1'b1;
    checks++; if (beat_data.size() !== 2) begin failures++; $display("FAIL rmid_beats got=%0d exp=2", beat_data.size()); end
    step;
    checks++; if (grant_id !== 2'd0 || tx_data !== 8'h70) begin failures++; $display("FAIL rmid_next got=%0d/%h exp=0/70", grant_id, tx_data); end
    req_valid = '0; req_last = '0;
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int pulses = 0;
    int pulse_at = -1;
    logic busy_after = 1'b1;
    do_reset;
    req_valid = 4'b0010; req_data[1] = 8'h61; req_data[2] = 8'h62;
    step;
    step; req_valid = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (timeout) begin pulses++; if (pulse_at < 0) pulse_at = i; end
      if (i == TO) busy_after = busy;
      step;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
    checks++; if (pulse_at !== TO - 1) begin failures++; $display("FAIL to_cycle got=%0d exp=%0d", pulse_at, TO - 1); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL to_idle got=%b exp=0", busy_after); end
    checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin failures++; $display("FAIL to_next got=%0d/%b exp=2/1", grant_id, busy); end
    req_valid = '0;
  endtask
`else
  task automatic test_no_timeout;
    int pulses = 0;
    do_reset;
    req_valid = 4'b0010; req_data[1] = 8'h61;
    step;
    step; req_valid = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (timeout) pulses++;
      step;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL nto_pulses got=%0d exp=0", pulses); end
    checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL nto_hold got=%0d/%b exp=1/1", grant_id, busy); end
    req_valid = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_lock_hold;
    test_backpressure;
    test_reset_mid;
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
